// File: rtl/bitslip_aligner.sv
// Frame-lane bitslip controller: slips the ISERDES until the frame word matches FRAME_PATTERN, then holds lock.
// Optional automatic relock on loss of lock is compiled in with `define BITSLIP_ALIGNER_RELOCK_EN.
module bitslip_aligner #(
    parameter int             W             = 8,
    parameter logic [W-1:0]   FRAME_PATTERN = W'(8'hF0),
    parameter int             SETTLE_CYCLES = 16,
    parameter int             MATCH_COUNT   = 8,
    parameter int             MAX_SLIPS     = 7,
    parameter int             MISS_LIMIT    = 4
) (
    input  logic         sample_clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] frame_word,
    output logic         bitslip,
    output logic         aligned,
    output logic         fail,
    output logic [7:0]   slip_count,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
    } state_t;

    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SLIP_MAX    = 8'(MAX_SLIPS);

    // Out-of-range parameters leave this marker block in the elaborated hierarchy.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || MATCH_COUNT < 1 || MATCH_COUNT > 255 ||
        MAX_SLIPS < 0 || MAX_SLIPS > 255 || MISS_LIMIT < 1 || MISS_LIMIT > 255) begin : g_param_range_bad
    end

    state_t     state_q, state_d;
    logic [7:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic       bitslip_q, bitslip_d;
    logic       aligned_q, aligned_d;
    logic       fail_q, fail_d;
    logic       busy_q, busy_d;
    logic       word_match;

`ifdef BITSLIP_ALIGNER_RELOCK_EN
    localparam logic [7:0] MISS_LAST = 8'(MISS_LIMIT - 1);
    logic [7:0] miss_cnt_q, miss_cnt_d;
`endif

    assign word_match = (frame_word == FRAME_PATTERN);

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slip_cnt_q   <= 8'd0;
            match_cnt_q  <= 8'd0;
            settle_cnt_q <= 8'd0;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BITSLIP_ALIGNER_RELOCK_EN
            miss_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            slip_cnt_q   <= slip_cnt_d;
            match_cnt_q  <= match_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            bitslip_q    <= bitslip_d;
            aligned_q    <= aligned_d;
            fail_q       <= fail_d;
            busy_q       <= busy_d;
`ifdef BITSLIP_ALIGNER_RELOCK_EN
            miss_cnt_q   <= miss_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        slip_cnt_d   = slip_cnt_q;
        match_cnt_d  = match_cnt_q;
        settle_cnt_d = settle_cnt_q;
`ifdef BITSLIP_ALIGNER_RELOCK_EN
        miss_cnt_d   = miss_cnt_q;
`endif
        if (start) begin
            state_d     = S_CHECK;
            slip_cnt_d  = 8'd0;
            match_cnt_d = 8'd0;
`ifdef BITSLIP_ALIGNER_RELOCK_EN
            miss_cnt_d  = 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: ;
                S_CHECK: begin
                    if (word_match) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        match_cnt_d = 8'd0;
                        state_d     = (slip_cnt_q == SLIP_MAX) ? S_FAIL : S_SLIP;
                    end
                end
                S_SLIP: begin
                    if (slip_cnt_q != 8'hFF) begin
                        slip_cnt_d = slip_cnt_q + 8'd1;
                    end
                    settle_cnt_d = SETTLE_LAST;
                    state_d      = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        match_cnt_d = 8'd0;
                        state_d     = S_CHECK;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                S_LOCKED: begin
`ifdef BITSLIP_ALIGNER_RELOCK_EN
                    if (word_match) begin
                        miss_cnt_d = 8'd0;
                    end else if (miss_cnt_q == MISS_LAST) begin
                        state_d     = S_CHECK;
                        slip_cnt_d  = 8'd0;
                        match_cnt_d = 8'd0;
                        miss_cnt_d  = 8'd0;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
`endif
                end
                S_FAIL: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies track the state register.
    always_comb begin
        bitslip_d = (state_d == S_SLIP);
        aligned_d = (state_d == S_LOCKED);
        fail_d    = (state_d == S_FAIL);
        busy_d    = (state_d == S_CHECK) || (state_d == S_SLIP) || (state_d == S_SETTLE);
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign fail       = fail_q;
    assign busy       = busy_q;
    assign slip_count = slip_cnt_q;

endmodule

// File: doc/bitslip_aligner.md
# bitslip_aligner

Frame-alignment controller for the Spartan-6 LVDS ADC receiver. It watches the deserialized frame-clock lane word and pulses `bitslip` into the ISERDES until the word matches the expected frame pattern. It then declares lock and keeps monitoring it. The block sits in the `sample_clk` domain next to the deserializer and drives the deserializer's `bitslip` input.

## Interface
Parameters:
- `W`, 8: deserialized word width.
- `FRAME_PATTERN`, 8'hF0: expected frame-lane word when aligned.
- `SETTLE_CYCLES`, 16: wait after each slip before the word is trusted (range 1..255).
- `MATCH_COUNT`, 8: consecutive matches required to declare lock (range 1..255).
- `MAX_SLIPS`, 7: slips attempted before failure (range 0..255).
- `MISS_LIMIT`, 4: consecutive mismatches in LOCKED that count as loss of lock (range 1..255).

Ports:
- `sample_clk`, in, 1: the only clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle request that (re)starts alignment.
- `frame_word`, in, W: deserialized frame-lane word, new value every cycle.
- `bitslip`, out, 1: one-cycle slip pulse to the ISERDES.
- `aligned`, out, 1: lock achieved and currently held.
- `fail`, out, 1: pattern not found after MAX_SLIPS slips.
- `slip_count`, out, 8: number of slips issued since the last start.
- `busy`, out, 1: high in every state except IDLE, LOCKED and FAIL.

## Operation
- States: IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL.
- IDLE
  - Waits for `start`.
  - On `start`: clear `slip_count`, the match counter and the miss counter, then go to CHECK.
- CHECK
  - Compares `frame_word == FRAME_PATTERN` once per cycle.
  - Match: match counter +1. When it reaches MATCH_COUNT, go to LOCKED.
  - Mismatch: clear the match counter.
    - If `slip_count == MAX_SLIPS`, go to FAIL.
    - Otherwise go to SLIP.
- SLIP
  - Lasts exactly one cycle, with `bitslip`=1.
  - `slip_count` +1, saturating at 255.
  - Then go to SETTLE.
- SETTLE
  - Waits SETTLE_CYCLES cycles; `frame_word` is ignored during this time.
  - Then go to CHECK with the match counter cleared.
- LOCKED
  - `aligned`=1.
  - Mismatch: miss counter +1. Match: miss counter cleared.
  - With the relock feature compiled in (see Configuration), the miss counter reaching MISS_LIMIT triggers a relock.
- FAIL
  - `fail`=1. Held until `start` or `reset`.
- `start` from any state other than IDLE behaves like `start` in IDLE: counters clear, go to CHECK. `start` takes priority over every other transition in that same cycle.
- `reset` overrides `start`.
- `reset` mid-sequence (including in SETTLE) returns to IDLE immediately. No further `bitslip` pulse is emitted after the reset cycle.
- With MAX_SLIPS=7 and W=8, all 8 bit positions are tested: the initial position plus 7 slips.

## Timing
- All outputs are registered.
- Reset values: `bitslip`=0, `aligned`=0, `fail`=0, `slip_count`=0, `busy`=0, state IDLE.
- `start` sampled in cycle t: `busy`=1 from t+1. The first comparison happens in cycle t+1.
- Mismatch sampled in cycle t (in CHECK): `bitslip`=1 in cycle t+1 only.
- `slip_count` shows the new value from t+2.
- SETTLE then occupies cycles t+2 .. t+1+SETTLE_CYCLES. The next comparison happens at t+2+SETTLE_CYCLES.
- The MATCH_COUNT-th consecutive match is sampled in cycle t: `aligned`=1 and `busy`=0 from t+1.
- The last permitted mismatch is sampled in cycle t: `fail`=1 from t+1.
- Minimum spacing between two `bitslip` pulses: SETTLE_CYCLES+2 cycles.
- `bitslip` never stays high for two consecutive cycles.

## Configuration
- `BITSLIP_ALIGNER_RELOCK_EN`
  - Defined: in LOCKED, when the miss counter reaches MISS_LIMIT:
    - `aligned` drops the following cycle.
    - `slip_count` and both counters clear.
    - The state goes to CHECK and alignment reruns automatically.
  - Undefined: the miss counter is not implemented. LOCKED is left only on `start` or `reset`, and `aligned` stays 1 whatever `frame_word` does.

## Test plan
- Already-aligned lane:
  - Stimulus: `frame_word`=8'hF0 constantly, `start` pulse.
  - Response: `aligned`=1 exactly 9 cycles after `start` (MATCH_COUNT=8), `slip_count`=0, no `bitslip` pulse.
- Misaligned by 3:
  - Stimulus: the bench model rotates `frame_word` by 1 bit on each `bitslip` and starts at 8'h1E.
  - Response: exactly 3 `bitslip` pulses, each 18 cycles apart; `slip_count`=3; `aligned`=1.
- Pattern absent:
  - Stimulus: `frame_word`=8'hAA constantly.
  - Response: 7 `bitslip` pulses, then `fail`=1, `aligned`=0, `slip_count`=7, `busy`=0.
- Loss of lock:
  - Stimulus: after lock, 4 consecutive 8'h0F words.
  - Response with the macro: `aligned` falls and realignment starts.
  - Response without the macro: `aligned` stays 1.
- Reset mid-settle:
  - Stimulus: assert `reset` 5 cycles after a `bitslip` pulse.
  - Response: all outputs return to their reset values the next cycle; no further `bitslip` pulse.
- Restart while locked:
  - Stimulus: `start` pulse in LOCKED.
  - Response: `aligned`=0 and `busy`=1 the next cycle; `slip_count`=0.
